// File: rtl/md5_brute_pkg.sv
// Shared definitions for the MD5 brute-force datapath.
//
// Contents:
//   MD5_BLOCK_W      width of one MD5 message block (512)
//   MD5_PAD_BYTE     first padding byte after the message (8'h80)
//   MD5_LEN_FIELD_W  width of the trailing message-length field (64)
//   builder_state_t  candidate block builder FSM states
//   md5_pad_template returns a block with padding and length filled in
//                    and all message bytes zero
package md5_brute_pkg;

  localparam int unsigned MD5_BLOCK_W     = 512;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;
  localparam int unsigned MD5_LEN_FIELD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } builder_state_t;

  // Message bytes 0..len-1 are left zero; byte len holds the pad marker and
  // the top 64 bits carry the bit length, little-endian, as MD5 expects.
  function automatic logic [MD5_BLOCK_W-1:0] md5_pad_template(input int unsigned len);
    logic [MD5_BLOCK_W-1:0] t;
    t = '0;
    t[8*len +: 8] = MD5_PAD_BYTE;
    t[MD5_BLOCK_W-1 -: MD5_LEN_FIELD_W] = MD5_LEN_FIELD_W'(len * 8);
    return t;
  endfunction

endpackage

// File: rtl/radix_digit_step.sv
// One base-RADIX digit extraction step.
//
// Ports:
//   work   in   32  remaining candidate value
//   quot   out  32  work / RADIX
//   digit  out   8  work % RADIX
//
// Purely combinational; RADIX is a constant so synthesis folds the divider
// into a constant-divisor network.
module radix_digit_step #(
  parameter int unsigned RADIX = 26
) (
  input  logic [31:0] work,
  output logic [31:0] quot,
  output logic [7:0]  digit
);

  localparam logic [31:0] DIVISOR = 32'(RADIX);

  assign quot  = work / DIVISOR;
  assign digit = 8'(work % DIVISOR);

endmodule

// File: rtl/md5_candidate_block_builder.sv
// Converts a 32-bit candidate index into a fixed-length password over a
// contiguous charset and emits it as one padded 512-bit MD5 message block.
//
// Ports:
//   CLK         in   1    clock, posedge
//   reset_n     in   1    asynchronous active-low reset
//   cand_valid  in   1    candidate index present
//   cand        in   32   candidate index
//   cand_last   in   1    final candidate, travels with cand
//   cand_ready  out  1    candidate accepted this cycle (high only in IDLE)
//   blk_valid   out  1    message block valid
//   blk         out  512  padded block, byte k at blk[8k+7:8k]
//   blk_last    out  1    block derives from the cand_last candidate
//   blk_ovf     out  1    cand >= RADIX**LEN, high digits dropped
//   blk_ready   in   1    MD5 core accepts the block
//   blk_index   out  32   latched original cand (only with CANDIDATE_ECHO_EN)
//
// Build option: define CANDIDATE_ECHO_EN to add blk_index.
//
// One digit is produced per cycle, least significant first, written from the
// right end of the password so the most significant digit ends in byte 0.
module md5_candidate_block_builder
  import md5_brute_pkg::*;
#(
  parameter int unsigned LEN       = 6,
  parameter int unsigned RADIX     = 26,
  parameter logic [7:0]  BASE_CHAR = 8'h61
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   cand_valid,
  input  logic [31:0]            cand,
  input  logic                   cand_last,
  output logic                   cand_ready,
  output logic                   blk_valid,
  output logic [MD5_BLOCK_W-1:0] blk,
  output logic                   blk_last,
  output logic                   blk_ovf,
  input  logic                   blk_ready
`ifdef CANDIDATE_ECHO_EN
  ,
  output logic [31:0]            blk_index
`endif
);

  localparam int unsigned            CNT_W        = 6;
  localparam logic [CNT_W-1:0]       LAST_IDX     = CNT_W'(LEN - 1);
  localparam logic [MD5_BLOCK_W-1:0] PAD_TEMPLATE = md5_pad_template(LEN);

  builder_state_t   state_q, state_d;
  logic [31:0]      work;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             step;

  logic [31:0]      quot;
  logic [7:0]       digit;
  logic [CNT_W-1:0] char_pos;
  logic [8:0]       char_lsb;

  radix_digit_step #(
    .RADIX (RADIX)
  ) u_step (
    .work  (work),
    .quot  (quot),
    .digit (digit)
  );

  assign char_pos = LAST_IDX - cnt;
  assign char_lsb = {char_pos, 3'b000};

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_ready = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cand_ready = 1'b1;
        if (cand_valid) begin
          accept  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        step = 1'b1;
        if (cnt == LAST_IDX) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // blk_valid is registered but tracks the EMIT state exactly.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      blk_valid <= 1'b0;
      blk       <= '0;
      blk_last  <= 1'b0;
      blk_ovf   <= 1'b0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      blk_valid <= (state_d == ST_EMIT);
      if (accept) begin
        work     <= cand;
        blk_last <= cand_last;
        blk_ovf  <= 1'b0;
        blk      <= PAD_TEMPLATE;
        cnt      <= '0;
      end else if (step) begin
        blk[char_lsb +: 8] <= BASE_CHAR + digit;
        work               <= quot;
        cnt                <= cnt + 1'b1;
        // Whatever survives LEN divisions is the part of cand that aliased.
        if (cnt == LAST_IDX) begin
          blk_ovf <= (quot != 32'd0);
        end
      end
    end
  end

`ifdef CANDIDATE_ECHO_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      blk_index <= '0;
    end else if (accept) begin
      blk_index <= cand;
    end
  end
`endif

endmodule
